// File: rtl/regs_pkg.sv
// Shared register-file constants, types and helpers used by the write-port arbiter
// and its pending-load scoreboard.
package regs_pkg;

  localparam int unsigned REG_AW         = 5;
  localparam int unsigned XLEN           = 32;
  localparam int unsigned NREGS          = 32;
  localparam int unsigned STARVE_MAX_DEF = 3;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   reg_data_t;

  typedef enum logic [1:0] {
    GntNone,
    GntEx,
    GntMem
  } gnt_e;

  typedef struct packed {
    logic      wen;
    reg_addr_t waddr;
    reg_data_t wdata;
  } wr_port_t;

  function automatic logic [NREGS-1:0] addr_mask(input reg_addr_t addr);
    logic [NREGS-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/regs_wport_arb_if.sv
// Bundle of EX/load-return write requests, load-pending hooks, ID source queries
// and the single register-file write port.
interface regs_wport_arb_if;
  import regs_pkg::*;

  logic      ex_valid;
  reg_addr_t ex_waddr;
  reg_data_t ex_wdata;
  logic      ex_ready;

  logic      mem_valid;
  reg_addr_t mem_waddr;
  reg_data_t mem_wdata;
  logic      mem_ready;

  logic      pend_set;
  reg_addr_t pend_addr;

  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  logic      stall_o;

  logic      reg_wen;
  reg_addr_t reg_waddr;
  reg_data_t reg_wdata;

  modport slave (
    input  ex_valid, ex_waddr, ex_wdata,
    input  mem_valid, mem_waddr, mem_wdata,
    input  pend_set, pend_addr, rs1_addr, rs2_addr,
    output ex_ready, mem_ready, stall_o,
    output reg_wen, reg_waddr, reg_wdata
  );

  modport master (
    output ex_valid, ex_waddr, ex_wdata,
    output mem_valid, mem_waddr, mem_wdata,
    output pend_set, pend_addr, rs1_addr, rs2_addr,
    input  ex_ready, mem_ready, stall_o,
    input  reg_wen, reg_waddr, reg_wdata
  );

endinterface

// File: rtl/regs_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register, set on load issue and
// cleared one cycle after the load's write reaches the write port. REGS_ARB_FWD_EN
// hides a pending bit while its clearing write is on the port (relies on RF bypass).
module regs_scoreboard
  import regs_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      stall
);

  logic [NREGS-1:0] pend_q, pend_d;
  logic [NREGS-1:0] set_mask, clr_mask;
  logic             set_hit;
  logic             clr_q, clr_d;
  reg_addr_t        clr_addr_q;
  logic             hit1, hit2;

  assign set_hit = set_en && (set_addr != '0);

  // A load returning to the register a new load is issuing to keeps the bit set, so
  // the clear is dropped here rather than delayed into a later conflict.
  assign clr_d = clr_en && (clr_addr != '0) && !(set_hit && (set_addr == clr_addr));

  always_comb begin
    set_mask  = set_hit ? addr_mask(set_addr) : '0;
    clr_mask  = clr_q ? addr_mask(clr_addr_q) : '0;
    pend_d    = (pend_q & ~clr_mask) | set_mask;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q     <= '0;
      clr_q      <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      pend_q     <= pend_d;
      clr_q      <= clr_d;
      clr_addr_q <= clr_addr;
    end
  end

  always_comb begin
    hit1 = pend_q[rs1_addr];
    hit2 = pend_q[rs2_addr];
`ifdef REGS_ARB_FWD_EN
    if (clr_q && (clr_addr_q == rs1_addr)) hit1 = 1'b0;
    if (clr_q && (clr_addr_q == rs2_addr)) hit2 = 1'b0;
`endif
    stall = hit1 || hit2;
  end

endmodule

// File: rtl/regs_wport_arb.sv
// Register-file write-port arbiter: load returns beat EX writebacks unless EX has
// starved for STARVE_MAX cycles; optional REGS_ARB_FWD_EN relaxes the load-use stall.
module regs_wport_arb
  import regs_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input logic             clk,
  input logic             rst,
  regs_wport_arb_if.slave bus
);

  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  logic [CntW-1:0] starve_q, starve_d;
  logic            ex_starved;
  gnt_e            gnt;
  logic            mem_xfer;
  wr_port_t        wr_q, wr_d;
  logic            sb_stall;

  assign ex_starved = (starve_q == CntMax);

  always_comb begin
    gnt = GntNone;
    if (bus.ex_valid && (!bus.mem_valid || ex_starved)) begin
      gnt = GntEx;
    end else if (bus.mem_valid) begin
      gnt = GntMem;
    end
    if (!rst) gnt = GntNone;
  end

  assign bus.ex_ready  = (gnt == GntEx);
  assign bus.mem_ready = (gnt == GntMem);
  assign mem_xfer      = (gnt == GntMem);

  always_comb begin
    starve_d = starve_q;
    if (!bus.ex_valid || (gnt == GntEx)) begin
      starve_d = '0;
    end else if (!ex_starved) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Writes to x0 are accepted but never reach the port; data is zeroed with them.
  always_comb begin
    wr_d = '0;
    unique case (gnt)
      GntEx: begin
        if (bus.ex_waddr != '0) begin
          wr_d.wen   = 1'b1;
          wr_d.waddr = bus.ex_waddr;
          wr_d.wdata = bus.ex_wdata;
        end
      end
      GntMem: begin
        if (bus.mem_waddr != '0) begin
          wr_d.wen   = 1'b1;
          wr_d.waddr = bus.mem_waddr;
          wr_d.wdata = bus.mem_wdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q <= '0;
      wr_q     <= '0;
    end else begin
      starve_q <= starve_d;
      wr_q     <= wr_d;
    end
  end

  assign bus.reg_wen   = wr_q.wen;
  assign bus.reg_waddr = wr_q.waddr;
  assign bus.reg_wdata = wr_q.wdata;

  regs_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (bus.pend_set),
    .set_addr (bus.pend_addr),
    .clr_en   (mem_xfer),
    .clr_addr (bus.mem_waddr),
    .rs1_addr (bus.rs1_addr),
    .rs2_addr (bus.rs2_addr),
    .stall    (sb_stall)
  );

  assign bus.stall_o = rst && sb_stall;

endmodule

// File: tb/tb_regs_wport_arb.sv
// Directed bench for regs_wport_arb: expected port writes are queued as stimulus is
// driven and popped when the registered write port updates.
module tb_regs_wport_arb;
  import regs_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regs_wport_arb_if bus ();

  regs_wport_arb #(.STARVE_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

`ifdef REGS_ARB_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic wen, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.wen   = wen;
    e.waddr = a;
    e.wdata = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      chk("reg_wen", 32'(bus.reg_wen), 32'(e.wen));
      chk("reg_waddr", 32'(bus.reg_waddr), 32'(e.waddr));
      chk("reg_wdata", bus.reg_wdata, e.wdata);
    end
  endtask

  task automatic idle();
    bus.ex_valid  = 1'b0;
    bus.mem_valid = 1'b0;
    bus.pend_set  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] pat;
    rst           = 1'b0;
    bus.ex_valid  = 1'b1;
    bus.ex_waddr  = 5'd1;
    bus.ex_wdata  = 32'h1;
    bus.mem_valid = 1'b1;
    bus.mem_waddr = 5'd2;
    bus.mem_wdata = 32'h2;
    bus.pend_set  = 1'b0;
    bus.pend_addr = '0;
    bus.rs1_addr  = '0;
    bus.rs2_addr  = '0;

    // Reset holds handshakes low even with requests pending.
    #1;
    chk("rst_ex_ready", 32'(bus.ex_ready), 32'd0);
    chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    push(1'b0, 5'd0, 32'h0);
    tick();
    rst = 1'b1;
    idle();

    // Lone EX writeback.
    bus.ex_valid = 1'b1;
    bus.ex_waddr = 5'd5;
    bus.ex_wdata = 32'h11;
    #1;
    chk("ex_only_ready", 32'(bus.ex_ready), 32'd1);
    chk("ex_only_mem_ready", 32'(bus.mem_ready), 32'd0);
    push(1'b1, 5'd5, 32'h11);
    tick();
    idle();
    #1;
    push(1'b0, 5'd0, 32'h0);
    tick();

    // Contention: mem, mem, mem, EX (starved), mem.
    bus.ex_valid  = 1'b1;
    bus.mem_valid = 1'b1;
    bus.ex_waddr  = 5'd3;
    bus.mem_waddr = 5'd4;
    pat = 5'b01000;
    for (int i = 0; i < 5; i++) begin
      bus.ex_wdata  = 32'hE0 + 32'(i);
      bus.mem_wdata = 32'hA0 + 32'(i);
      #1;
      chk("arb_ex_ready", 32'(bus.ex_ready), 32'(pat[i]));
      chk("arb_mem_ready", 32'(bus.mem_ready), 32'(!pat[i]));
      if (pat[i]) push(1'b1, 5'd3, 32'hE0 + 32'(i));
      else        push(1'b1, 5'd4, 32'hA0 + 32'(i));
      tick();
    end
    idle();

    // Load-use stall on x7 and its release.
    bus.pend_set  = 1'b1;
    bus.pend_addr = 5'd7;
    #1;
    push(1'b0, 5'd0, 32'h0);
    tick();
    bus.pend_set = 1'b0;
    bus.rs1_addr = 5'd7;
    #1;
    chk("pend7_stall", 32'(bus.stall_o), 32'd1);
    push(1'b0, 5'd0, 32'h0);
    tick();
    bus.mem_valid = 1'b1;
    bus.mem_waddr = 5'd7;
    bus.mem_wdata = 32'h77;
    #1;
    chk("ld7_mem_ready", 32'(bus.mem_ready), 32'd1);
    chk("ld7_stall_xfer", 32'(bus.stall_o), 32'd1);
    push(1'b1, 5'd7, 32'h77);
    tick();
    idle();
    #1;
    chk("ld7_stall_on_port", 32'(bus.stall_o), Fwd ? 32'd0 : 32'd1);
    push(1'b0, 5'd0, 32'h0);
    tick();
    #1;
    chk("ld7_stall_after", 32'(bus.stall_o), 32'd0);
    bus.rs1_addr = 5'd0;

    // Set and clear of x9 in the same cycle: set wins.
    bus.pend_set  = 1'b1;
    bus.pend_addr = 5'd9;
    bus.mem_valid = 1'b1;
    bus.mem_waddr = 5'd9;
    bus.mem_wdata = 32'h99;
    bus.rs2_addr  = 5'd9;
    #1;
    chk("x9_mem_ready", 32'(bus.mem_ready), 32'd1);
    push(1'b1, 5'd9, 32'h99);
    tick();
    idle();
    #1;
    chk("x9_stall_a", 32'(bus.stall_o), 32'd1);
    push(1'b0, 5'd0, 32'h0);
    tick();
    #1;
    chk("x9_stall_b", 32'(bus.stall_o), 32'd1);
    bus.rs2_addr = 5'd0;

    // x0: accepted but never written, never pending.
    bus.mem_valid = 1'b1;
    bus.mem_waddr = 5'd0;
    bus.mem_wdata = 32'hFFFF;
    #1;
    chk("x0_mem_ready", 32'(bus.mem_ready), 32'd1);
    push(1'b0, 5'd0, 32'h0);
    tick();
    idle();
    bus.pend_set  = 1'b1;
    bus.pend_addr = 5'd0;
    #1;
    chk("x0_stall_a", 32'(bus.stall_o), 32'd0);
    push(1'b0, 5'd0, 32'h0);
    tick();
    bus.pend_set = 1'b0;
    #1;
    chk("x0_stall_b", 32'(bus.stall_o), 32'd0);
    push(1'b0, 5'd0, 32'h0);
    tick();

    // Mid-operation reset with pending bits 1..3 and starve count at 2.
    bus.pend_set  = 1'b1;
    bus.pend_addr = 5'd3;
    #1;
    push(1'b0, 5'd0, 32'h0);
    tick();
    bus.ex_valid  = 1'b1;
    bus.mem_valid = 1'b1;
    bus.ex_waddr  = 5'd10;
    bus.ex_wdata  = 32'hBEEF;
    bus.mem_waddr = 5'd11;
    for (int i = 1; i <= 2; i++) begin
      bus.pend_addr = 5'(i);
      bus.mem_wdata = 32'hC0 + 32'(i);
      #1;
      chk("pre_rst_mem_ready", 32'(bus.mem_ready), 32'd1);
      push(1'b1, 5'd11, 32'hC0 + 32'(i));
      tick();
    end
    bus.pend_set = 1'b0;
    bus.rs1_addr = 5'd1;
    bus.rs2_addr = 5'd3;
    #1;
    chk("pre_rst_stall", 32'(bus.stall_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ex_ready", 32'(bus.ex_ready), 32'd0);
    chk("mid_rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("mid_rst_stall", 32'(bus.stall_o), 32'd0);
    push(1'b0, 5'd0, 32'h0);
    tick();
    rst = 1'b1;
    idle();
    bus.rs2_addr = 5'd2;
    #1;
    chk("post_rst_stall_12", 32'(bus.stall_o), 32'd0);
    bus.rs1_addr = 5'd3;
    bus.rs2_addr = 5'd9;
    #1;
    chk("post_rst_stall_39", 32'(bus.stall_o), 32'd0);
    push(1'b0, 5'd0, 32'h0);
    tick();

    // Starve count restarted from 0: three mem wins before EX.
    bus.ex_valid  = 1'b1;
    bus.mem_valid = 1'b1;
    pat = 5'b01000;
    for (int i = 0; i < 4; i++) begin
      bus.mem_wdata = 32'hD0 + 32'(i);
      #1;
      chk("post_rst_ex_ready", 32'(bus.ex_ready), 32'(pat[i]));
      chk("post_rst_mem_ready", 32'(bus.mem_ready), 32'(!pat[i]));
      if (pat[i]) push(1'b1, 5'd10, 32'hBEEF);
      else        push(1'b1, 5'd11, 32'hD0 + 32'(i));
      tick();
    end
    idle();
    #1;
    push(1'b0, 5'd0, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regs_wport_arb.md
REGS_WPORT_ARB -- requirements
Module: regs_wport_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3, meaning the number of consecutive denied EX cycles after which EX wins arbitration.
REQ-002 SHALL have port clk  input  1  clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port ex_valid  input  1  EX writeback request.
REQ-005 SHALL have port ex_waddr  input  5  EX destination register.
REQ-006 SHALL have port ex_wdata  input  32  EX result.
REQ-007 SHALL have port ex_ready  output  1  EX request accepted this cycle.
REQ-008 SHALL have port mem_valid  input  1  load-return writeback request.
REQ-009 SHALL have port mem_waddr  input  5  load destination register.
REQ-010 SHALL have port mem_wdata  input  32  load data.
REQ-011 SHALL have port mem_ready  output  1  load-return accepted this cycle.
REQ-012 SHALL have port pend_set  input  1  load issued; mark pend_addr pending.
REQ-013 SHALL have port pend_addr  input  5  register made pending by an issued load.
REQ-014 SHALL have ports rs1_addr and rs2_addr, input, 5 bits each, ID source registers.
REQ-015 SHALL have port stall_o  output  1  ID must hold because a source register is pending.
REQ-016 SHALL have ports reg_wen (output, 1), reg_waddr (output, 5) and reg_wdata (output, 32), the single register-file write port.

Function
REQ-017 SHALL perform one handshake per requester per cycle: a transfer occurs when valid and ready are both high in the same cycle; ready is combinational from valid and the arbitration state.
REQ-018 SHALL give mem priority when both requests are valid, except that EX wins when starve_cnt == STARVE_MAX.
REQ-019 SHALL use a starve_cnt counter that increments when ex_valid is high and ex_ready is low, saturates at STARVE_MAX, and clears to 0 on any EX transfer or cycle with ex_valid low.
REQ-020 SHALL register the winning transfer onto reg_wen/reg_waddr/reg_wdata at the next posedge (latency 1), with reg_wen low in cycles with no transfer.
REQ-021 SHALL accept a transfer whose waddr is 0 normally (ready high) while driving reg_wen 0 for it.
REQ-022 SHALL keep a 32-bit pending scoreboard: pend_set with pend_addr != 0 sets bit pend_addr; a mem transfer clears bit mem_waddr; when set and clear hit the same address in the same cycle, set wins.
REQ-023 SHALL hold bit 0 of the scoreboard at 0 permanently.
REQ-024 SHALL drive stall_o combinationally high when rs1_addr or rs2_addr addresses a pending bit, subject to REQ-027/REQ-028.
REQ-025 SHALL leave the EX-side ordering to the pipeline, performing no ordering check between EX and mem writes to the same register.

Reset
REQ-026 SHALL, while rst is 0 at a posedge, clear reg_wen/reg_waddr/reg_wdata, starve_cnt and the scoreboard to 0, and SHALL hold ex_ready, mem_ready and stall_o at 0 while rst is low, including mid-transfer; a transfer in flight is dropped.

Configuration
REQ-027 SHALL, with macro REGS_ARB_FWD_EN defined, suppress stall_o for a source register whose pending bit is being cleared by the write currently on the reg_wen/reg_waddr outputs; this relies on the register-file write bypass.
REQ-028 SHALL, without REGS_ARB_FWD_EN, stall on any set pending bit, regardless of writes in progress.

Structure
REQ-029 SHALL take REG_AW=5, XLEN=32, NREGS=32 and the STARVE_MAX default from shared package regs_pkg.
REQ-030 SHALL place the scoreboard in one sub-module regs_scoreboard (set/clear/query), with arbitration and the output register in the top module.

Verification
REQ-031 Only ex_valid, ex_waddr=5, ex_wdata=0x11 -> ex_ready=1; next cycle reg_wen=1, reg_waddr=5, reg_wdata=0x11.
REQ-032 ex_valid and mem_valid held high for 5 cycles (STARVE_MAX=3) -> mem wins cycles 1-3, EX wins cycle 4, mem wins cycle 5.
REQ-033 pend_set with pend_addr=7, then rs1_addr=7 -> stall_o=1; mem transfer with waddr=7 -> stall_o falls when the write appears on the outputs if REGS_ARB_FWD_EN is defined, one cycle later if not.
REQ-034 pend_set addr=9 and mem transfer waddr=9 in the same cycle -> bit 9 remains set and stall_o=1 for rs2_addr=9.
REQ-035 mem transfer with waddr=0, wdata=0xFFFF -> mem_ready=1, reg_wen stays 0; pend_set with pend_addr=0 -> stall_o never asserted for rs1_addr=0.
REQ-036 rst low for 1 cycle while 3 pending bits are set and starve_cnt=2 -> all outputs 0, scoreboard empty, starve_cnt=0 after release.
